// File: rtl/comp_seq_ctrl.sv
// Multi-cycle unsigned magnitude compare, one SLICE-bit slice per cycle,
// MSB slice first, stopping at the first unequal slice.
module comp_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WIDTH-1:0]                  a,
  input  logic [WIDTH-1:0]                  b,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic                              lt,
  output logic                              eq,
  output logic                              gt,
  output logic [$clog2(WIDTH/SLICE):0]      slices_used,
  output logic                              busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int CW     = $clog2(NSLICE) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if ((WIDTH % SLICE) != 0 || WIDTH < SLICE) begin : g_bad_width
    $error("comp_seq_ctrl: WIDTH must be a non-zero multiple of SLICE");
  end

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nx;
  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic             sl_gt;
  logic             sl_lt;
  logic             sl_last_eq;

  // Operands shift up each step, so the live slice always sits at the top.
  assign a_sl       = a_q[WIDTH-1 -: SLICE];
  assign b_sl       = b_q[WIDTH-1 -: SLICE];
  assign sl_gt      = a_sl > b_sl;
  assign sl_lt      = a_sl < b_sl;
  assign sl_last_eq = (a_sl == b_sl) && (idx == '0);
  assign cnt_nx     = cnt + CW'(1);

  assign in_ready  = (state == S_IDLE);
  assign res_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx         <= '0;
      cnt         <= '0;
      lt          <= 1'b0;
      eq          <= 1'b0;
      gt          <= 1'b0;
      slices_used <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            idx   <= IW'(NSLICE - 1);
            cnt   <= '0;
            state <= S_CMP;
          end
        end
        S_CMP: begin
          cnt <= cnt_nx;
          idx <= idx - IW'(1);
          a_q <= a_q << SLICE;
          b_q <= b_q << SLICE;
          unique case (1'b1)
            sl_gt: begin
              gt          <= 1'b1;
              slices_used <= cnt_nx;
              state       <= S_DONE;
            end
            sl_lt: begin
              lt          <= 1'b1;
              slices_used <= cnt_nx;
              state       <= S_DONE;
            end
            sl_last_eq: begin
              eq          <= 1'b1;
              slices_used <= cnt_nx;
              state       <= S_DONE;
            end
            default: ;
          endcase
        end
        S_DONE: begin
          if (res_ready) begin
            lt    <= 1'b0;
            eq    <= 1'b0;
            gt    <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comp_seq_ctrl.sv
// Directed and reference-checked bench for comp_seq_ctrl,
// WIDTH=16, SLICE=4.
module tb_comp_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        res_valid;
  logic        res_ready;
  logic        lt;
  logic        eq;
  logic        gt;
  logic [2:0]  slices_used;
  logic        busy;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  comp_seq_ctrl #(.WIDTH(16), .SLICE(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .lt          (lt),
    .eq          (eq),
    .gt          (gt),
    .slices_used (slices_used),
    .busy        (busy)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // flags are {lt,eq,gt}; hold = cycles of res_ready=0 after res_valid
  task automatic run_op(input logic [15:0] ta,
                        input logic [15:0] tb_,
                        input logic [2:0]  ef,
                        input int          esu,
                        input int          hold);
    int lat;
    @(negedge clk);
    check("in_ready_pre", in_ready, 1);
    a        = ta;
    b        = tb_;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("busy_cmp", busy, 1);
    check("in_ready_cmp", in_ready, 0);
    lat = 0;
    while (!res_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, esu);
    check("flags", {lt, eq, gt}, ef);
    check("onehot", $onehot({lt, eq, gt}), 1);
    check("slices_used", slices_used, esu);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      a        = 16'($urandom);
      b        = 16'($urandom);
      @(posedge clk);
      #1;
      check("bp_valid", res_valid, 1);
      check("bp_flags", {lt, eq, gt}, ef);
      check("bp_su", slices_used, esu);
      check("bp_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check("post_valid", res_valid, 0);
    check("post_flags", {lt, eq, gt}, 3'b000);
    check("post_in_ready", in_ready, 1);
  endtask

  function automatic int ref_su(input logic [15:0] x, input logic [15:0] y);
    int su;
    logic [15:0] d;
    d  = x ^ y;
    su = 4;
    for (int i = 0; i < 4; i++)
      if (d[i*4 +: 4] != 4'h0) su = 4 - i;
    return su;
  endfunction

  function automatic logic [2:0] ref_flags(input logic [15:0] x,
                                           input logic [15:0] y);
    if (x < y) return 3'b100;
    if (x == y) return 3'b010;
    return 3'b001;
  endfunction

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    int          nib;
    rst       = 1'b1;
    in_valid  = 1'b0;
    res_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_flags", {lt, eq, gt}, 3'b000);
    check("rst_su", slices_used, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op(16'h8000, 16'h7FFF, 3'b001, 1, 0);
    run_op(16'h1234, 16'h1234, 3'b010, 4, 0);
    run_op(16'h0000, 16'h0000, 3'b010, 4, 0);
    run_op(16'hFFFF, 16'hFFFF, 3'b010, 4, 0);
    run_op(16'h1233, 16'h1234, 3'b100, 4, 0);
    run_op(16'hA5FF, 16'hA6FF, 3'b100, 2, 0);
    run_op(16'h00F0, 16'h0F00, 3'b100, 2, 5);
    run_op(16'h0001, 16'h0000, 3'b001, 4, 0);

    // reset during the second CMP cycle discards the operation
    @(negedge clk);
    a        = 16'h1200;
    b        = 16'h1234;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("mid_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_in_ready", in_ready, 1);
    check("mid_res_valid", res_valid, 0);
    check("mid_flags", {lt, eq, gt}, 3'b000);
    check("mid_busy_after", busy, 0);
    check("mid_su", slices_used, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op(16'h0000, 16'hFFFF, 3'b100, 1, 0);

    for (int n = 0; n < 1500; n++) begin
      ra = 16'($urandom);
      if (n % 2 == 0) begin
        rb = 16'($urandom);
      end else begin
        nib = $urandom_range(0, 3);
        rb  = ra;
        rb[nib*4 +: 4] = 4'($urandom);
      end
      run_op(ra, rb, ref_flags(ra, rb), ref_su(ra, rb), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
